// File: rtl/fifo_mcu_wr_pack.sv
// fifo_mcu_wr_pack
// Packs RATIO narrow MCU writes into one wide word and queues the wide words
// in a simple-dual-port RAM. The reader gets a registered one-cycle rd_valid
// pulse. Overflow and underflow are sticky until flush or reset.
module fifo_mcu_wr_pack #(
  parameter int IN_W       = 8,
  parameter int RATIO      = 2,
  parameter int DEPTH_LOG2 = 6,
  parameter int LSB_FIRST  = 1,
  localparam int OUT_W     = IN_W * RATIO,
  localparam int IDX_W     = $clog2(RATIO)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [IN_W-1:0]       wr_data,
  input  logic                  rd_en,
  output logic [OUT_W-1:0]      rd_data,
  output logic                  rd_valid,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic [IDX_W-1:0]      partial,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LEVEL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] LEVEL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(RATIO - 1);
  localparam logic [IDX_W-1:0]    IDX_ONE    = IDX_W'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  // Registered state and outputs
  logic [RATIO-1:0][IN_W-1:0] lanes_q, lanes_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [DEPTH_LOG2-1:0]      wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0]      rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]        level_q, level_d;
  logic                       full_q, full_d;
  logic                       empty_q, empty_d;
  logic                       overflow_q, overflow_d;
  logic                       underflow_q, underflow_d;
  logic                       rd_valid_q, rd_valid_d;
  logic [OUT_W-1:0]           rd_data_q, rd_data_d;

  // Wide-word storage
  logic [OUT_W-1:0] mem [DEPTH];

  // Per-cycle decisions
  logic             last_lane;
  logic             wr_acc;
  logic             commit;
  logic             rd_acc;
  logic [IDX_W-1:0] lane_sel;

  // Accept/commit/read decisions, all taken from the state at cycle start
  always_comb begin
    last_lane = (idx_q == IDX_LAST);
    // A write that only fills a lane is always taken; only a completing write
    // into a full FIFO is dropped, even if a read frees a slot this cycle.
    wr_acc    = wr_en && !flush && !(last_lane && full_q);
    commit    = wr_acc && last_lane;
    // No fall-through: a read on an empty FIFO is rejected even if a commit
    // lands in the same cycle.
    rd_acc    = rd_en && !flush && !empty_q;
    lane_sel  = (LSB_FIRST != 0) ? idx_q : (IDX_LAST - idx_q);
  end

  // Next-state logic for packer, pointers, level, flags and read port
  always_comb begin
    // NOTE: every signal gets a default here so no path can hold a stale value
    // and infer a latch.
    lanes_d     = lanes_q;
    idx_d       = idx_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;

    if (wr_acc) begin
      lanes_d[lane_sel] = wr_data;
      idx_d             = last_lane ? '0 : (idx_q + IDX_ONE);
    end
    if (commit) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rptr_d     = rptr_q + PTR_ONE;
      rd_valid_d = 1'b1;
      rd_data_d  = mem[rptr_q];
    end

    unique case ({commit, rd_acc})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase

    if (wr_en && !flush && !wr_acc) overflow_d  = 1'b1;
    if (rd_en && !flush && empty_q) underflow_d = 1'b1;

    // Flush wins over any write or read in the same cycle; rd_data holds.
    if (flush) begin
      idx_d       = '0;
      wptr_d      = '0;
      rptr_d      = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      rd_valid_d  = 1'b0;
    end

    full_d  = (level_d == LEVEL_FULL);
    empty_d = (level_d == '0);
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      lanes_q     <= '0;
      idx_q       <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      lanes_q     <= lanes_d;
      idx_q       <= idx_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // RAM write port: the completed word including the current lane
  always_ff @(posedge clk) begin
    // NOTE: the memory array has no reset so it maps onto block RAM; the level
    // counter alone decides which entries hold valid data.
    if (commit) mem[wptr_q] <= lanes_d;
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign level     = level_q;
  assign partial   = idx_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_mcu_wr_pack.sv
// Self-checking bench for fifo_mcu_wr_pack (IN_W=8, RATIO=2, DEPTH_LOG2=2).
// Two instances share all inputs: one packs LSB-first, one MSB-first.
// A reference model tracks stored words; accepted reads push the expected
// word onto a scoreboard queue that is popped when rd_valid is due.
module tb_fifo_mcu_wr_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = '0;
  logic        rd_en = 1'b0;
  logic        flush = 1'b0;

  logic [15:0] rd_data_l, rd_data_m;
  logic        rd_valid_l, rd_valid_m;
  logic        full_l, full_m, empty_l, empty_m;
  logic [2:0]  level_l, level_m;
  logic [0:0]  partial_l, partial_m;
  logic        ovf_l, ovf_m, unf_l, unf_m;

  fifo_mcu_wr_pack #(.IN_W(8), .RATIO(2), .DEPTH_LOG2(2), .LSB_FIRST(1)) u_dut_lsb (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data_l), .rd_valid(rd_valid_l), .flush(flush), .full(full_l),
    .empty(empty_l), .level(level_l), .partial(partial_l), .overflow(ovf_l),
    .underflow(unf_l)
  );

  fifo_mcu_wr_pack #(.IN_W(8), .RATIO(2), .DEPTH_LOG2(2), .LSB_FIRST(0)) u_dut_msb (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data_m), .rd_valid(rd_valid_m), .flush(flush), .full(full_m),
    .empty(empty_m), .level(level_m), .partial(partial_m), .overflow(ovf_m),
    .underflow(unf_m)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [15:0] m_store[$];
  logic [15:0] exp_q[$];
  logic [7:0]  m_lane [2];
  int          m_idx;
  bit          m_ovf, m_unf, m_rv;
  int          n_rd;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic model_reset();
    m_store.delete();
    exp_q.delete();
    m_idx = 0; m_ovf = 0; m_unf = 0; m_rv = 0;
  endtask

  // Drive one cycle, advance the model, then score rd_valid/rd_data and state.
  task automatic cycle(input logic we, input logic [7:0] wd, input logic re, input logic fl);
    logic [15:0] e;
    logic [11:0] exp_st, got_l, got_m;
    bit          full_s, empty_s, rd_ok;
    wr_en = we; wr_data = wd; rd_en = re; flush = fl;
    if (fl) begin
      m_store.delete(); m_idx = 0; m_ovf = 0; m_unf = 0; m_rv = 0;
    end else begin
      full_s  = (m_store.size() == 4);
      empty_s = (m_store.size() == 0);
      rd_ok   = re && !empty_s;
      if (re && empty_s) m_unf = 1;
      if (we) begin
        if (m_idx == 1 && full_s) m_ovf = 1;
        else begin
          m_lane[m_idx] = wd;
          if (m_idx == 1) begin
            m_store.push_back({m_lane[1], m_lane[0]});
            m_idx = 0;
          end else m_idx = 1;
        end
      end
      if (rd_ok) exp_q.push_back(m_store.pop_front());
      m_rv = rd_ok;
    end
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;

    n_checks++;
    if (rd_valid_l !== m_rv || rd_valid_m !== m_rv)
      $display("FAIL rd_valid: got lsb=%b msb=%b expected %b", rd_valid_l, rd_valid_m, m_rv);
    else n_pass++;
    if (m_rv) begin
      e = exp_q.pop_front();
      n_rd++;
      n_checks++;
      if (rd_data_l !== e || rd_data_m !== {e[7:0], e[15:8]})
        $display("FAIL rd_data: got lsb=%h msb=%h expected lsb=%h msb=%h",
                 rd_data_l, rd_data_m, e, {e[7:0], e[15:8]});
      else n_pass++;
    end
    exp_st = {3'(m_store.size()), 1'(m_idx), m_store.size() == 4, m_store.size() == 0,
              m_ovf, m_unf, 4'b0};
    got_l  = {level_l, partial_l, full_l, empty_l, ovf_l, unf_l, 4'b0};
    got_m  = {level_m, partial_m, full_m, empty_m, ovf_m, unf_m, 4'b0};
    n_checks++;
    if (got_l !== exp_st || got_m !== exp_st)
      $display("FAIL state{level,partial,full,empty,ovf,unf}: got lsb=%h msb=%h expected %h",
               got_l, got_m, exp_st);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_checks++;
    if ({rd_valid_l, full_l, empty_l, ovf_l, unf_l, level_l, partial_l} !== 9'b00100_000_0 ||
        rd_data_l !== 16'h0000)
      $display("FAIL reset_values: got v=%b f=%b e=%b o=%b u=%b lvl=%0d p=%0d d=%h expected 0 0 1 0 0 0 0 0000",
               rd_valid_l, full_l, empty_l, ovf_l, unf_l, level_l, partial_l, rd_data_l);
    else n_pass++;
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_pack();
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    n_checks++;
    if (partial_l !== 1'b1 || level_l !== 3'd0)
      $display("FAIL pack_first: got partial=%0d level=%0d expected 1 0", partial_l, level_l);
    else n_pass++;
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    n_checks++;
    if (partial_l !== 1'b0 || level_l !== 3'd1)
      $display("FAIL pack_commit: got partial=%0d level=%0d expected 0 1", partial_l, level_l);
    else n_pass++;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (rd_valid_l !== 1'b1 || rd_data_l !== 16'h2211 || rd_data_m !== 16'h1122 || level_l !== 3'd0)
      $display("FAIL pack_read: got v=%b lsb=%h msb=%h level=%0d expected 1 2211 1122 0",
               rd_valid_l, rd_data_l, rd_data_m, level_l);
    else n_pass++;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (rd_valid_l !== 1'b0 || rd_data_l !== 16'h2211)
      $display("FAIL rd_data_hold: got v=%b d=%h expected 0 2211", rd_valid_l, rd_data_l);
    else n_pass++;
  endtask

  task automatic test_full_overflow();
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    n_checks++;
    if (level_l !== 3'd4 || full_l !== 1'b1)
      $display("FAIL fill: got level=%0d full=%b expected 4 1", level_l, full_l);
    else n_pass++;
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    n_checks++;
    if (partial_l !== 1'b1 || ovf_l !== 1'b0)
      $display("FAIL partial_when_full: got partial=%0d ovf=%b expected 1 0", partial_l, ovf_l);
    else n_pass++;
    cycle(1'b1, 8'hBB, 1'b0, 1'b0);
    n_checks++;
    if (ovf_l !== 1'b1 || partial_l !== 1'b1 || level_l !== 3'd4)
      $display("FAIL overflow_drop: got ovf=%b partial=%0d level=%0d expected 1 1 4", ovf_l, partial_l, level_l);
    else n_pass++;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'hBB, 1'b0, 1'b0);
    n_checks++;
    if (level_l !== 3'd4 || full_l !== 1'b1)
      $display("FAIL refill: got level=%0d full=%b expected 4 1", level_l, full_l);
    else n_pass++;
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (rd_data_l !== 16'hBBAA || rd_data_m !== 16'hAABB)
      $display("FAIL fourth_read: got lsb=%h msb=%h expected BBAA AABB", rd_data_l, rd_data_m);
    else n_pass++;
  endtask

  task automatic test_underflow_and_simul();
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (unf_l !== 1'b1 || rd_valid_l !== 1'b0)
      $display("FAIL empty_read: got unf=%b v=%b expected 1 0", unf_l, rd_valid_l);
    else n_pass++;
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h31 + 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'h36, 1'b1, 1'b0);
    n_checks++;
    if (level_l !== 3'd2 || rd_data_l !== 16'h3231)
      $display("FAIL commit_and_read: got level=%0d d=%h expected 2 3231", level_l, rd_data_l);
    else n_pass++;
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (rd_data_l !== 16'h3635 || empty_l !== 1'b1)
      $display("FAIL simul_order: got d=%h empty=%b expected 3635 1", rd_data_l, empty_l);
    else n_pass++;
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if (ovf_l !== 1'b0 || unf_l !== 1'b0)
      $display("FAIL flush_flags: got ovf=%b unf=%b expected 0 0", ovf_l, unf_l);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int  start_rd;
    bit  re;
    start_rd = n_rd;
    for (int i = 0; i < 40; i++) begin
      re = (m_store.size() >= 3) || (m_store.size() > 0 && ($urandom_range(0, 1) == 1));
      cycle(1'b1, 8'(i * 7 + 3), re, 1'b0);
      n_checks++;
      if (level_l > 3'd4 || ovf_l !== 1'b0 || unf_l !== 1'b0)
        $display("FAIL wrap_flags: got level=%0d ovf=%b unf=%b expected <=4 0 0", level_l, ovf_l, unf_l);
      else n_pass++;
    end
    for (int k = 0; k < 8 && m_store.size() > 0; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (n_rd - start_rd != 20 || empty_l !== 1'b1)
      $display("FAIL wrap_count: got words=%0d empty=%b expected 20 1", n_rd - start_rd, empty_l);
    else n_pass++;
  endtask

  task automatic test_flush();
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
    n_checks++;
    if (level_l !== 3'd3 || partial_l !== 1'b1 || unf_l !== 1'b1)
      $display("FAIL flush_setup: got level=%0d partial=%0d unf=%b expected 3 1 1", level_l, partial_l, unf_l);
    else n_pass++;
    cycle(1'b1, 8'h99, 1'b1, 1'b1);
    n_checks++;
    if ({level_l, empty_l, full_l, partial_l, ovf_l, unf_l, rd_valid_l} !== 9'b000_1_0_0_0_0_0)
      $display("FAIL flush_state: got level=%0d e=%b f=%b p=%0d o=%b u=%b v=%b expected 0 1 0 0 0 0 0",
               level_l, empty_l, full_l, partial_l, ovf_l, unf_l, rd_valid_l);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
    n_checks++;
    if (level_l !== 3'd3 || partial_l !== 1'b1)
      $display("FAIL rst_setup: got level=%0d partial=%0d expected 3 1", level_l, partial_l);
    else n_pass++;
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({rd_valid_l, full_l, empty_l, ovf_l, unf_l, level_l, partial_l} !== 9'b00100_000_0 ||
        rd_data_l !== 16'h0000)
      $display("FAIL async_reset: got v=%b f=%b e=%b o=%b u=%b lvl=%0d p=%0d d=%h expected 0 0 1 0 0 0 0 0000",
               rd_valid_l, full_l, empty_l, ovf_l, unf_l, level_l, partial_l, rd_data_l);
    else n_pass++;
    model_reset();
    #2 rst = 1'b0;
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    cycle(1'b1, 8'h88, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (rd_data_l !== 16'h8877)
      $display("FAIL post_reset: got d=%h expected 8877", rd_data_l);
    else n_pass++;
  endtask

  initial begin
    n_rd = 0;
    model_reset();
    test_reset();
    test_pack();
    test_full_overflow();
    test_underflow_and_simul();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
